nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/adder4.sv | 25 ++
 rtl/nibble_serial_adder.sv | 112 +++++++++++
 tb/tb_nibble_serial_adder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding and the slice width.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder4.sv
// 4-bit ripple-carry adder slice.
// Pure combinational full-adder chain.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit slice, WIDTH/4 cycles per add.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub (a - b) port.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / NIBBLE_W;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             b_inv;
    logic             c0;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_co;

    // Subtract is folded into capture: a + ~b + 1.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign b_inv = sub;
    assign c0    = sub ? 1'b1 : cin;
`else
    assign b_inv = 1'b0;
    assign c0    = cin;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST);
    assign sum       = sum_q;
    assign cout      = cout_q;

    assign nib_a = a_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];

    adder4 u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                carry_q <= c0;
                cnt     <= '0;
            end else if (state == RUN) begin
                sum_q[int'(cnt)*NIBBLE_W +: NIBBLE_W] <= nib_s;
                carry_q <= nib_co;
                cnt     <= cnt + 1'b1;
                if (last) cout_q <= nib_co;
            end
        end
    end

    // Operands need no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b_inv ? ~b : b;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (WIDTH=16 and WIDTH=4).
// Scoreboard queues hold expected results pushed at acceptance.
module tb_nibble_serial_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
    } exp16_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        sub4;
    logic        out_valid4;
    logic        out_ready4;
    logic [3:0]  sum4;
    logic        cout4;

    exp16_t      sbq[$];
    logic [4:0]  sbq4[$];
    int          total;
    int          passed;
    int          fails;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub       (sub4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts, input int hold);
        logic [16:0] full;
        exp16_t      e;
        int          lat;
        @(negedge clk);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        if (ts)
            full = {1'b0, ta} + {1'b0, ~tb_} + 17'd1;
        else
            full = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
        sbq.push_back('{sum: full[15:0], cout: full[16]});
        @(negedge clk);
        // Garbage on inputs while busy must be ignored.
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = ~tc;
        sub = ~ts;
        lat = 1;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency16", lat, 32'd5);
        in_valid = 1'b0;
        e = sbq[0];
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(e.sum));
            chk("hold_cout", 32'(cout), 32'(e.cout));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        e = sbq.pop_front();
        chk("sum16", 32'(sum), 32'(e.sum));
        chk("cout16", 32'(cout), 32'(e.cout));
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_,
                       input logic tc);
        logic [4:0] full;
        int         lat;
        @(negedge clk);
        a4        = ta;
        b4        = tb_;
        cin4      = tc;
        in_valid4 = 1'b1;
        full = {1'b0, ta} + {1'b0, tb_} + {4'd0, tc};
        sbq4.push_back(full);
        chk("in_ready4", 32'(in_ready4), 32'd1);
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency4", lat, 32'd2);
        out_ready4 = 1'b1;
        full = sbq4.pop_front();
        chk("sum4", 32'(sum4), 32'(full[3:0]));
        chk("cout4", 32'(cout4), 32'(full[4]));
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("ready4_back", 32'(in_ready4), 32'd1);
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        fails      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        a4         = '0;
        b4         = '0;
        cin4       = 1'b0;
        sub4       = 1'b0;
        out_ready4 = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        op16(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        op16(16'hA5C3, 16'h5A3D, 1'b1, 1'b0, 3);
        for (int i = 0; i < 3; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, i);

        // Abort an operation mid-run with reset.
        @(negedge clk);
        a        = 16'h1234;
        b        = 16'h4321;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_out", 32'(out_valid), 32'd0);
        end
        op16(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        op16(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        op16(16'h0007, 16'h0005, 1'b1, 1'b1, 1);
        op16(16'h8000, 16'h8000, 1'b0, 1'b1, 0);
`endif

        op4(4'h9, 4'h8, 1'b1);
        op4(4'hF, 4'h0, 1'b0);
        op4(4'h7, 4'h8, 1'b1);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("sb4_empty", 32'(sbq4.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
